// File: rtl/instr_mem_pkg.sv
// instr_mem shared types and constants.
// Widths, idle instruction and FSM state encodings.
package instr_mem_pkg;

  localparam int datawidth = 32;
  localparam int addrwidth = 8;

  localparam logic [datawidth-1:0] NOP_INSTR =
    32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CSUM = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_if.sv
// instr_mem boot loader byte stream.
// Source drives valid/byte/last, memory returns ready.
interface instr_mem_if;

  logic       ld_valid;
  logic [7:0] ld_byte;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output ld_valid,
    output ld_byte,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_byte,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/instr_mem_imem_array.sv
// imem_array: word storage, sync write, comb read.
// Contents have no reset.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write port, one word per edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem.sv
// instr_mem: byte-serial loaded instruction memory.
// Optional checksum stage: define IMEM_CHECKSUM_EN.
module instr_mem #(
  parameter int DEPTH = 2**instr_mem_pkg::addrwidth,
  parameter int AW    = instr_mem_pkg::addrwidth,
  parameter logic [31:0] NOP_INSTR =
    instr_mem_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] instr_addr,
  output logic [31:0]   instr,
  instr_mem_if.slave    ld,
  input  logic          reload,
  output logic          load_done,
  output logic          load_err,
  output logic          cpu_rst_n
);
  import instr_mem_pkg::*;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          full_q, full_d;
  logic [31:0]   asm_q, asm_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          crst_q, crst_d;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]   acc_q, acc_d;
`endif

  logic          accept;
  logic [31:0]   word;
  logic          we;
  logic [31:0]   rdata;

  assign ld.ld_ready = (state_q != RUN);
  assign accept = ld.ld_valid & ld.ld_ready;

  // byte assembler, counters and FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    asm_d   = asm_q;
    err_d   = err_q;
    done_d  = done_q;
    crst_d  = crst_q;
`ifdef IMEM_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    we      = 1'b0;
    word    = asm_q;
    word[{cnt_q, 3'b000} +: 8] = ld.ld_byte;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          asm_d = word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3 || ld.ld_last) begin
            asm_d = '0;
            cnt_d = '0;
            if (full_q) begin
              err_d = 1'b1;
            end else begin
              we = 1'b1;
`ifdef IMEM_CHECKSUM_EN
              acc_d = acc_q + word;
`endif
              if (ptr_q == AW'(DEPTH-1))
                full_d = 1'b1;
              else
                ptr_d = ptr_q + AW'(1);
            end
          end
          if (ld.ld_last) begin
`ifdef IMEM_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = RUN;
            done_d  = 1'b1;
            crst_d  = 1'b1;
`endif
          end
        end
      end
`ifdef IMEM_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          asm_d = word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            asm_d = '0;
            cnt_d = '0;
            if (word != acc_q) err_d = 1'b1;
            state_d = RUN;
            done_d  = 1'b1;
            crst_d  = 1'b1;
          end
        end
      end
`endif
      RUN: begin
        if (reload) begin
          state_d = LOAD;
          cnt_d   = '0;
          ptr_d   = '0;
          full_d  = 1'b0;
          asm_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          crst_d  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // loader state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      crst_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      done_q  <= done_d;
      crst_q  <= crst_d;
`ifdef IMEM_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (32)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q),
    .wdata (word),
    .raddr (instr_addr),
    .rdata (rdata)
  );

  assign instr     = (state_q == RUN) ? rdata : NOP_INSTR;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign cpu_rst_n = crst_q;

endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed vectors for instr_mem.
// Covers the IMEM_CHECKSUM_EN build when defined.
module tb_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  instr_addr = '0;
  logic [31:0] instr;
  logic        reload = 1'b0;
  logic        load_done;
  logic        load_err;
  logic        cpu_rst_n;

  instr_mem_if ld ();

  instr_mem u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_addr (instr_addr),
    .instr      (instr),
    .ld         (ld.slave),
    .reload     (reload),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_rst_n  (cpu_rst_n)
  );

  always #5 clk = ~clk;

`ifdef IMEM_CHECKSUM_EN
  localparam int CSB = 4;
`else
  localparam int CSB = 0;
`endif

  typedef struct {
    int          phase;
    logic [7:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  always @(posedge clk)
    if (ld.ld_valid && ld.ld_ready) acc_cnt++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic last);
    int n;
    n = 0;
    ld.ld_valid = 1'b1;
    ld.ld_byte  = b;
    ld.ld_last  = last;
    while (!ld.ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ld.ld_ready) begin
      errors++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    @(negedge clk);
    ld.ld_valid = 1'b0;
    ld.ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic last);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], last && k == 3);
    end
  endtask

  task automatic finish_csum(input logic [31:0] s);
`ifdef IMEM_CHECKSUM_EN
    for (int k = 0; k < 4; k++)
      send_byte(s[8*k +: 8], 1'b0);
`else
    if (s == 32'hFFFF_FFFF) @(negedge clk);
`endif
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic run_vecs(input int ph);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].phase == ph) begin
        instr_addr = vecs[i].addr;
        #1;
        check($sformatf("rd_p%0d_a%0d", ph,
                        vecs[i].addr),
              instr, vecs[i].exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 8'd0,   32'h0000_0013};
    vecs[1] = '{1, 8'd1,   32'h0010_0093};
    vecs[2] = '{2, 8'd255, 32'h1000_00FF};
    vecs[3] = '{2, 8'd0,   32'h1000_0000};
    vecs[4] = '{2, 8'd128, 32'h1000_0080};
    vecs[5] = '{3, 8'd0,   32'hDDCC_BBAA};
    vecs[6] = '{3, 8'd1,   32'h0000_00EE};
    vecs[7] = '{3, 8'd2,   32'h1000_0002};
    vecs[8] = '{4, 8'd0,   32'hCAFE_F00D};

    ld.ld_valid = 1'b0;
    ld.ld_byte  = '0;
    ld.ld_last  = 1'b0;
    instr_addr  = 8'h55;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(ld.ld_ready), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_cpu", 32'(cpu_rst_n), 32'd0);
    check("rst_instr", instr, 32'h13);
    rst_n = 1'b1;
    @(negedge clk);

    // two-word program
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    instr_addr = 8'd1;
    #1;
    check("pre_instr", instr, 32'h13);
    check("pre_cpu", 32'(cpu_rst_n), 32'd0);
    check("pre_ready", 32'(ld.ld_ready), 32'd1);
    check("pre_done", 32'(load_done), 32'd0);
    send_byte(8'h00, 1'b1);
    finish_csum(32'h0010_00A6);
    check("p1_done", 32'(load_done), 32'd1);
    check("p1_cpu", 32'(cpu_rst_n), 32'd1);
    check("p1_ready", 32'(ld.ld_ready), 32'd0);
    check("p1_err", 32'(load_err), 32'd0);
    run_vecs(1);

    // overflow: 257 words
    pulse_reload();
    for (int i = 0; i < 257; i++) begin
      send_word(32'h1000_0000 + 32'(i), i == 256);
      if (i == 255)
        check("ovf_pre_err", 32'(load_err), 32'd0);
    end
    finish_csum(32'h0000_7F80);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_done", 32'(load_done), 32'd1);
    run_vecs(2);

    pulse_reload();
    check("rl_ready", 32'(ld.ld_ready), 32'd1);
    check("rl_done", 32'(load_done), 32'd0);
    check("rl_cpu", 32'(cpu_rst_n), 32'd0);
    check("rl_err", 32'(load_err), 32'd0);
    instr_addr = 8'd0;
    #1;
    check("rl_instr", instr, 32'h13);

    // five-byte program with idle gaps
    acc_cnt = 0;
    send_byte(8'hAA, 1'b0);
    @(negedge clk);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    repeat (3) @(negedge clk);
    send_byte(8'hDD, 1'b0);
    @(negedge clk);
    send_byte(8'hEE, 1'b1);
    finish_csum(32'hDDCC_BC98);
    check("p3_done", 32'(load_done), 32'd1);
    ld.ld_valid = 1'b1;
    ld.ld_byte  = 8'h77;
    repeat (5) @(negedge clk);
    ld.ld_valid = 1'b0;
    check("p3_count", 32'(acc_cnt), 32'(5 + CSB));
    run_vecs(3);

    // async reset in the middle of a load
    pulse_reload();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_ready", 32'(ld.ld_ready), 32'd1);
    check("mr_cpu", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'hCAFE_F00D, 1'b1);
    finish_csum(32'hCAFE_F00D);
    check("p4_done", 32'(load_done), 32'd1);
    check("p4_err", 32'(load_err), 32'd0);
    run_vecs(4);

`ifdef IMEM_CHECKSUM_EN
    pulse_reload();
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b1);
    check("cs_ready", 32'(ld.ld_ready), 32'd1);
    check("cs_done", 32'(load_done), 32'd0);
    send_word(32'h3, 1'b0);
    check("cs_ok_done", 32'(load_done), 32'd1);
    check("cs_ok_err", 32'(load_err), 32'd0);
    pulse_reload();
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b1);
    send_word(32'h4, 1'b0);
    check("cs_bad_done", 32'(load_done), 32'd1);
    check("cs_bad_err", 32'(load_err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
# instr_mem

Instruction memory that answers the fetch unit's word address with the instruction at that address, and that is filled after reset by a byte-serial boot loader. It sits between the external program source and the single-cycle CPU core. It holds the core in reset until a complete program has been written. Reads are combinational, as the single-cycle datapath requires; all loading is sequential.

## Interface
- `DEPTH`, 256: number of 32-bit instruction words.
- `AW`, 8: word-address width; `DEPTH` = 2^`AW`.
- `NOP_INSTR`, 32'h0000_0013: word returned while not in RUN.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_addr` in `addrwidth` (= `AW`): word address from the fetch unit (byte PC bits [9:2]).
- `instr` out `datawidth`: instruction word.
- `ld_valid` in 1: loader byte valid.
- `ld_byte` in 8: loader byte.
- `ld_last` in 1: qualifies the final program byte.
- `ld_ready` out 1: byte accepted when `ld_valid` & `ld_ready`.
- `reload` in 1: single-cycle pulse; restarts loading from RUN.
- `load_done` out 1: program loaded and CPU released.
- `load_err` out 1: sticky error (overflow or, if enabled, checksum mismatch).
- `cpu_rst_n` out 1: active-low reset to the CPU core; low until RUN.

## Operation
- States:
  - LOAD: accept program bytes.
  - CSUM: accept 4 checksum bytes; exists only with the macro.
  - RUN: serve fetches.
- Reset enters LOAD with `byte_cnt`=0, `word_ptr`=0, `asm_word`=0.
- Byte assembly is little-endian: byte k of a word goes to bits [8k+7:8k].
- On the 4th accepted byte, the completed word is written to `mem[word_ptr]` and `word_ptr` increments.
- `ld_last` accepted:
  - The partial word is zero-filled in the unwritten upper bytes and written.
  - The FSM goes to CSUM (macro on) or RUN (macro off).
- Overflow: a word write when `word_ptr` == `DEPTH`-1 has already been written is dropped. `load_err` sets. Loading continues until `ld_last`; `word_ptr` saturates and does not wrap.
- `ld_ready` = 1 in LOAD and CSUM, 0 in RUN.
- `instr` = `mem[instr_addr]` in RUN; `NOP_INSTR` otherwise.
- `reload` in RUN:
  - Next state is LOAD.
  - Counters and the checksum accumulator clear, and `load_err` clears.
  - `load_done` and `cpu_rst_n` drop.
  - Memory contents are kept and are overwritten as loading proceeds.
- `reload` in LOAD or CSUM is ignored.
- Reset mid-load: everything returns to LOAD with counters cleared. Memory contents are undefined; there is no memory reset.

## Timing
- Reset values:
  - `ld_ready`=1 (state LOAD).
  - `load_done`=0, `load_err`=0, `cpu_rst_n`=0.
  - `instr`=`NOP_INSTR`.
- Memory write occurs on the clock edge that accepts the word's last byte.
- `instr` read latency is 0: combinational from `instr_addr` and the state.
- RUN, `load_done`=1 and `cpu_rst_n`=1 are all registered. They are asserted the cycle after the final accepted byte (the `ld_last` byte, or the 4th checksum byte).
- `cpu_rst_n` is driven from a flop, so the CPU's PC starts at 0 cleanly one edge later.
- `reload` takes effect on the next edge; `ld_ready` is 1 the following cycle.
- `ld_valid` may be held high with `ld_ready` low; no byte is consumed in that case.

## Configuration
- `IMEM_CHECKSUM_EN`, defined:
  - A 32-bit accumulator sums every written word, mod 2^32, including the zero-filled partial word.
  - CSUM accepts 4 bytes, little-endian; `ld_last` is ignored in CSUM.
  - A mismatch sets `load_err`. RUN is entered regardless.
- Not defined:
  - No CSUM state and no accumulator.
  - `load_err` reflects overflow only.

## Structure
- Shared header holds:
  - `datawidth` (32) and `addrwidth` (8).
  - `NOP_INSTR`.
  - State encodings: LOAD=2'd0, CSUM=2'd1, RUN=2'd2.
- Sub-module `imem_array`:
  - `DEPTH`x32 storage.
  - Synchronous write port (`we`, `waddr`, `wdata`).
  - Combinational read port.
  - No reset.
- The top level holds the FSM, the byte assembler, the counters and the checksum logic.

## Test plan
- Load 8 bytes 13 00 00 00 / 93 00 10 00 with `ld_last` on byte 8:
  - `mem[0]`=0x00000013, `mem[1]`=0x00100093.
  - `load_done`=1 and `cpu_rst_n`=1 one cycle after byte 8.
  - `instr_addr`=1 gives 0x00100093.
- Before load completes, any `instr_addr` gives `instr`=0x00000013, with `cpu_rst_n`=0 and `ld_ready`=1.
- Load 5 bytes AA BB CC DD EE with `ld_last` on EE:
  - `mem[1]`=0x000000EE.
  - `ld_valid` held high with gaps: exactly 5 bytes consumed.
- Load 257 words:
  - `load_err`=1, and `mem[255]` holds word 255's data.
  - The final write is dropped.
  - `load_done`=1 after `ld_last`.
- With `IMEM_CHECKSUM_EN`, words 0x1 and 0x2 followed by checksum bytes:
  - Checksum 03 00 00 00 gives `load_err`=0.
  - Checksum 04 00 00 00 gives `load_err`=1.
- In RUN:
  - Pulse `reload`: next cycle `ld_ready`=1, `load_done`=0, `cpu_rst_n`=0, `load_err` cleared.
  - Assert `rst_n`=0 mid-load after 2 bytes, then reload one word: `mem[0]` holds the new word.
